// File: rtl/gt_tx_link_ctrl.sv
// GT TX bring-up and link supervisor: sequences PLL/datapath resets, waits for
// a stable reset-done with timeout and bounded retry, then watches the link.
module gt_tx_link_ctrl #(
    parameter int GT_CHN_NUM       = 6,
    parameter int RESET_PULSE_CYC  = 64,
    parameter int DONE_TIMEOUT_CYC = 262144,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int SYNC_STAGES      = 3
) (
    input  logic                               gt_init_clk,
    input  logic                               gt_reset_n,
    input  logic                               start,
    input  logic [GT_CHN_NUM-1:0]              chn_mask,
    input  logic [GT_CHN_NUM-1:0]              gt_powergood_in,
    input  logic [GT_CHN_NUM-1:0]              txpmaresetdone_in,
    input  logic                               tx_resetdone_in,
    output logic                               gt_reset_tx_pll_and_datapath,
    output logic                               gt_reset_tx_datapath,
    output logic                               link_up,
    output logic                               link_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [15:0]                        lost_cnt,
    output logic [2:0]                         state_o
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int PULSE_W = (RESET_PULSE_CYC > 1) ? $clog2(RESET_PULSE_CYC) : 1;
    localparam int TMO_W   = $clog2(DONE_TIMEOUT_CYC);
    localparam int STB_W   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

    localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(RESET_PULSE_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(DONE_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STABLE_LAST = STB_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PG   = 3'd1,
        RST_PLL   = 3'd2,
        RST_DP    = 3'd3,
        WAIT_DONE = 3'd4,
        STABLE    = 3'd5,
        UP        = 3'd6,
        FAIL      = 3'd7
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Input synchronisers; done vector carries tx_resetdone in the MSB.
    logic [GT_CHN_NUM-1:0] pg_sync   [SYNC_STAGES];
    logic [GT_CHN_NUM:0]   done_sync [SYNC_STAGES];

    always_ff @(posedge gt_init_clk) begin
        pg_sync[0]   <= gt_powergood_in;
        done_sync[0] <= {tx_resetdone_in, txpmaresetdone_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pg_sync[i]   <= pg_sync[i-1];
            done_sync[i] <= done_sync[i-1];
        end
    end

    state_t                state, state_n;
    logic [GT_CHN_NUM-1:0] mask_q, mask_n;
    logic [PULSE_W-1:0]    pulse_cnt, pulse_n;
    logic [TMO_W-1:0]      timer, timer_n;
    logic [STB_W-1:0]      stable_cnt, stable_n;
    logic [RETRY_W-1:0]    retry_n;
    logic [15:0]           lost_n;
    logic                  pg_ok, done_ok;

    assign pg_ok   = &(pg_sync[SYNC_STAGES-1] | ~mask_q);
    assign done_ok = done_sync[SYNC_STAGES-1][GT_CHN_NUM] &
                     (&(done_sync[SYNC_STAGES-1][GT_CHN_NUM-1:0] | ~mask_q));

    always_comb begin
        state_n  = state;
        mask_n   = mask_q;
        pulse_n  = pulse_cnt;
        timer_n  = timer;
        stable_n = stable_cnt;
        retry_n  = retry_cnt;
        lost_n   = lost_cnt;
        if (!start) begin
            state_n = IDLE;
            retry_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|chn_mask) begin
                        state_n = WAIT_PG;
                        mask_n  = chn_mask;
                    end
                end
                WAIT_PG: begin
                    if (pg_ok) begin
                        state_n = RST_PLL;
                        pulse_n = '0;
                    end
                end
                RST_PLL: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_n = WAIT_DONE;
                        timer_n = '0;
                    end else begin
                        pulse_n = pulse_cnt + 1'b1;
                    end
                end
                RST_DP: begin
                    if (!pg_ok) begin
                        state_n = WAIT_PG;
                    end else if (pulse_cnt == PULSE_LAST) begin
                        state_n = WAIT_DONE;
                        timer_n = '0;
                    end else begin
                        pulse_n = pulse_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!pg_ok) begin
                        state_n = WAIT_PG;
                    end else if (done_ok) begin
                        state_n  = STABLE;
                        stable_n = '0;
                    end else if (timer == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_n = retry_cnt + 1'b1;
                            state_n = RST_PLL;
                            pulse_n = '0;
                        end else begin
                            state_n = FAIL;
                        end
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                // Timer is held here so a glitch back to WAIT_DONE keeps its budget.
                STABLE: begin
                    if (!pg_ok) begin
                        state_n = WAIT_PG;
                    end else if (!done_ok) begin
                        state_n = WAIT_DONE;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state_n = UP;
                        retry_n = '0;
                    end else begin
                        stable_n = stable_cnt + 1'b1;
                    end
                end
                UP: begin
                    if (!pg_ok) begin
                        state_n = WAIT_PG;
                        lost_n  = sat_inc16(lost_cnt);
                    end else if (!done_ok) begin
                        state_n = RST_DP;
                        pulse_n = '0;
                        lost_n  = sat_inc16(lost_cnt);
                    end
                end
                FAIL: begin
                    state_n = FAIL;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with state_o.
    always_ff @(posedge gt_init_clk) begin
        if (!gt_reset_n) begin
            state                        <= IDLE;
            mask_q                       <= '0;
            pulse_cnt                    <= '0;
            timer                        <= '0;
            stable_cnt                   <= '0;
            retry_cnt                    <= '0;
            lost_cnt                     <= '0;
            gt_reset_tx_pll_and_datapath <= 1'b1;
            gt_reset_tx_datapath         <= 1'b0;
            link_up                      <= 1'b0;
            link_fail                    <= 1'b0;
        end else begin
            state                        <= state_n;
            mask_q                       <= mask_n;
            pulse_cnt                    <= pulse_n;
            timer                        <= timer_n;
            stable_cnt                   <= stable_n;
            retry_cnt                    <= retry_n;
            lost_cnt                     <= lost_n;
            gt_reset_tx_pll_and_datapath <= (state_n == IDLE) || (state_n == WAIT_PG) ||
                                            (state_n == RST_PLL) || (state_n == FAIL);
            gt_reset_tx_datapath         <= (state_n == RST_DP);
            link_up                      <= (state_n == UP);
            link_fail                    <= (state_n == FAIL);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_gt_tx_link_ctrl.sv
// Directed bench for gt_tx_link_ctrl with small timing parameters.
module tb_gt_tx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] mask;
    logic [5:0] pg;
    logic [5:0] pma;
    logic       done;
    logic       pll;
    logic       dp;
    logic       link_up;
    logic       link_fail;
    logic [1:0] retry_cnt;
    logic [15:0] lost_cnt;
    logic [2:0] state_o;

    int n_chk  = 0;
    int n_fail = 0;

    gt_tx_link_ctrl #(
        .GT_CHN_NUM      (6),
        .RESET_PULSE_CYC (4),
        .DONE_TIMEOUT_CYC(32),
        .STABLE_CYC      (8),
        .MAX_RETRY       (2),
        .SYNC_STAGES     (2)
    ) dut (
        .gt_init_clk                  (clk),
        .gt_reset_n                   (rst_n),
        .start                        (start),
        .chn_mask                     (mask),
        .gt_powergood_in              (pg),
        .txpmaresetdone_in            (pma),
        .tx_resetdone_in              (done),
        .gt_reset_tx_pll_and_datapath (pll),
        .gt_reset_tx_datapath         (dp),
        .link_up                      (link_up),
        .link_fail                    (link_fail),
        .retry_cnt                    (retry_cnt),
        .lost_cnt                     (lost_cnt),
        .state_o                      (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state_o !== s && n < max) begin
            n++;
            tick();
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    initial begin
        int n;
        logic pll_seen;

        rst_n = 1'b0; start = 1'b0; mask = 6'h3F; pg = 6'h3F; pma = 6'h00; done = 1'b0;
        repeat (3) tick();
        check("rst_pll",   32'(pll), 1);
        check("rst_dp",    32'(dp), 0);
        check("rst_up",    32'(link_up), 0);
        check("rst_fail",  32'(link_fail), 0);
        check("rst_retry", 32'(retry_cnt), 0);
        check("rst_lost",  32'(lost_cnt), 0);
        check("rst_state", 32'(state_o), 0);

        // Clean bring-up, all channels used
        rst_n = 1'b1; start = 1'b1;
        wait_state(3'd2, 10, "bringup_rst_pll");
        n = 0;
        while (state_o == 3'd2 && pll && n < 20) begin n++; tick(); end
        check("bringup_pll_len", n, 4);
        check("bringup_pll_low", 32'(pll), 0);
        check("bringup_wait_done", 32'(state_o), 4);
        repeat (10) tick();
        pma = 6'h3F; done = 1'b1;
        n = 0;
        while (!link_up && n < 40) begin n++; tick(); end
        check("bringup_up_latency", n, 11);
        check("bringup_state_up", 32'(state_o), 6);
        check("bringup_retry", 32'(retry_cnt), 0);
        check("bringup_fail", 32'(link_fail), 0);

        // One-cycle tx_resetdone drop: datapath-only recovery
        done = 1'b0; tick(); done = 1'b1;
        wait_state(3'd3, 10, "dp_entry");
        check("dp_lost", 32'(lost_cnt), 1);
        check("dp_up_low", 32'(link_up), 0);
        n = 0; pll_seen = 1'b0;
        while (state_o == 3'd3 && dp && n < 20) begin
            if (pll) pll_seen = 1'b1;
            n++;
            tick();
        end
        check("dp_len", n, 4);
        check("dp_pll_stays_low", 32'(pll_seen), 0);
        check("dp_released", 32'(dp), 0);
        wait_state(3'd6, 40, "dp_relink");
        check("dp_relink_up", 32'(link_up), 1);

        // pg[0] loss in UP
        pg = 6'h3E;
        wait_state(3'd1, 10, "pg_loss_wait_pg");
        check("pg_loss_pll", 32'(pll), 1);
        check("pg_loss_lost", 32'(lost_cnt), 2);
        check("pg_loss_up", 32'(link_up), 0);
        pg = 6'h3F;
        wait_state(3'd6, 60, "pg_relink");

        // pg and done drop together: counted once
        pg = 6'h3E; done = 1'b0;
        wait_state(3'd1, 10, "dual_loss_wait_pg");
        check("dual_loss_lost", 32'(lost_cnt), 3);
        repeat (5) tick();
        check("dual_loss_hold", 32'(state_o), 1);
        check("dual_loss_lost_hold", 32'(lost_cnt), 3);
        pg = 6'h3F; done = 1'b1;
        wait_state(3'd6, 60, "dual_relink");

        // Done lost for good; abort by start=0 during second WAIT_DONE
        done = 1'b0;
        n = 0;
        while (!(state_o == 3'd4 && retry_cnt == 2'd1) && n < 150) begin n++; tick(); end
        check("abort_state", 32'(state_o), 4);
        check("abort_retry_pre", 32'(retry_cnt), 1);
        check("abort_lost", 32'(lost_cnt), 4);
        start = 1'b0; tick();
        check("abort_idle", 32'(state_o), 0);
        check("abort_retry_clr", 32'(retry_cnt), 0);
        check("abort_pll", 32'(pll), 1);

        // Done never arrives: three pulses then FAIL
        start = 1'b1;
        wait_state(3'd2, 10, "retry_first_pulse");
        for (int p = 0; p < 3; p++) begin
            check("retry_cnt_at_pulse", 32'(retry_cnt), p);
            n = 0;
            while (state_o == 3'd2 && pll && n < 20) begin n++; tick(); end
            check("retry_pulse_len", n, 4);
            n = 0;
            while (state_o == 3'd4 && !pll && n < 100) begin n++; tick(); end
            check("retry_gap_len", n, 32);
        end
        check("fail_state", 32'(state_o), 7);
        check("fail_flag", 32'(link_fail), 1);
        check("fail_pll", 32'(pll), 1);
        check("fail_retry", 32'(retry_cnt), 2);
        pma = 6'h3F; done = 1'b1;
        repeat (5) tick();
        check("fail_sticky", 32'(state_o), 7);
        start = 1'b0; tick();
        check("fail_exit_idle", 32'(state_o), 0);
        check("fail_exit_flag", 32'(link_fail), 0);

        // Zero mask stays idle; then partial mask ignores unused channels
        mask = 6'h00; start = 1'b1;
        repeat (4) tick();
        check("zero_mask_idle", 32'(state_o), 0);
        mask = 6'h07; pg = 6'h07; pma = 6'h3F; done = 1'b1;
        wait_state(3'd6, 60, "mask07_up");
        check("mask07_link", 32'(link_up), 1);
        pma = 6'h1F;
        repeat (6) tick();
        check("unmasked_drop_state", 32'(state_o), 6);
        check("unmasked_drop_up", 32'(link_up), 1);
        check("unmasked_drop_lost", 32'(lost_cnt), 4);

        // Reset while UP
        rst_n = 1'b0; tick();
        check("rst_up_state", 32'(state_o), 0);
        check("rst_up_pll",   32'(pll), 1);
        check("rst_up_dp",    32'(dp), 0);
        check("rst_up_link",  32'(link_up), 0);
        check("rst_up_fail",  32'(link_fail), 0);
        check("rst_up_retry", 32'(retry_cnt), 0);
        check("rst_up_lost",  32'(lost_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
